fft_cmplx_twiddle_mult: RTL
===========================

// Module: fft_cmplx_twiddle_mult
// PURPOSE
//  Parametrised, pipelined complex multiplier: FFT butterfly sample x twiddle factor.
//  Sits between butterfly stage N output and stage N+1 input.
//  Adds over the previous generation:
//   - ready/valid backpressure with clock-enable stalls (no gated clocks)
//   - per-sample conjugate mode for IFFT
//   - round-half-up scaling and saturation with an overflow flag
//   - sideband tag carried through the pipeline
// PARAMETERS
//  DW     25  sample component width (signed, re and im each)
//  TW     18  twiddle component width (signed Q1.(TW-1); 1.0 ~ 2^(TW-1)-1)
//  OW     DW  output component width (signed)
//  TAG_W  8   sideband width (bin index etc.), passed through untouched
// PORTS
//  clk_i       in   1        clock
//  rst_i       in   1        asynchronous reset, active-high
//  s_valid_i   in   1        input sample valid
//  s_ready_o   out  1        block can accept input this cycle
//  s_data_i    in   2*DW     {re[DW-1:0], im[DW-1:0]}, re in MSBs
//  w_i         in   2*TW     twiddle {re, im}, re in MSBs; sampled with s_data_i
//  conj_i      in   1        1: multiply by conj(w) (IFFT); sampled with s_data_i
//  tag_i       in   TAG_W    sideband, sampled with s_data_i
//  m_valid_o   out  1        output valid
//  m_ready_i   in   1        downstream accepts output
//  m_data_o    out  2*OW     {re, im} product, re in MSBs
//  m_tag_o     out  TAG_W    tag of the sample on m_data_o
//  m_ovf_o     out  1        saturation occurred on re or im of this output
// BEHAVIOUR
//  - Reset: all stage valids, m_valid_o, m_data_o, m_tag_o and m_ovf_o clear to 0.
//    s_ready_o is 1 once reset is released.
//  - Pipeline: 4 stages, latency exactly 4 cycles from the accepted input to m_valid_o.
//    S1: register a, b, c, d, conj, tag.
//    S2: products ac, bd, ad, bc, each DW+TW bits signed.
//    S3: sums, DW+TW+1 bits signed.
//        conj=0: re = ac - bd, im = ad + bc.
//        conj=1: re = ac + bd, im = bc - ad.
//    S4: round, shift and saturate each component (see scaling rules).
//  - Flow control: advance = !m_valid_o | m_ready_i. All stages enable on advance.
//    s_ready_o = advance (combinational).
//    Bubbles are not collapsed; a stall freezes every stage together.
//  - Handshakes: transfer in when s_valid_i & s_ready_o; transfer out when m_valid_o & m_ready_i.
//    While m_valid_o=1 & m_ready_i=0, m_data_o, m_tag_o and m_ovf_o hold stable.
//    Full throughput: 1 sample/cycle while m_ready_i=1.
//  - Scaling rules:
//    rounded = (sum + 2^(TW-2)) >>> (TW-1), arithmetic shift.
//    If rounded is outside [-2^(OW-1), 2^(OW-1)-1], clamp to that limit and set m_ovf_o for this sample.
//  - Corner case: the -1.0 twiddle (-2^(TW-1)) is legal; the full-scale product saturates rather than wraps.
//  - Simultaneous in and out transfers in the same cycle are normal streaming, with no loss or duplication.
//  - Reset mid-operation discards all in-flight samples immediately; no output appears for them after release.
// STRUCTURE
//  - Shared package fft_pkg:
//    cplx_t #(W) packed struct {re, im};
//    function sat_round() (sum width, shift, OW -> value + ovf flag);
//    localparam MULT_LAT = 4.
//  - One sub-module: fft_round_sat, the S4 combinational round/saturate, instanced once per component.
//  - Products are written as plain signed multiplies so that synthesis maps them to DSP slices;
//    S1/S2 registers absorb into the DSP A/B/M registers.
// TESTING (DW=25, TW=18, OW=25, all values decimal)
//  1. Unity twiddle:
//     x=(1000,0), w=(131071,0), conj=0 -> out (1000,0), ovf=0, exactly 4 cycles after accept.
//  2. Conjugate -j:
//     x=(0,1000), w=(0,-131072), conj=0 -> (1000,0).
//     Same input with conj=1 -> (-1000,0).
//  3. Saturation:
//     x=(-16777216,-16777216), w=(-131072,-131072)
//     -> re=0, im=16777215, m_ovf_o=1 on that beat only.
//  4. Backpressure:
//     stream 10 tagged samples and hold m_ready_i=0 for 3 cycles mid-stream.
//     -> s_ready_o=0 during the hold, outputs stable, all 10 tags out in order, none lost or duplicated.
//  5. Reset mid-op:
//     3 samples in flight, pulse rst_i.
//     -> m_valid_o=0 asynchronously, no output for them after release, next sample correct at latency 4.
//  6. Random streaming:
//     1e5 random x/w/conj with random m_ready_i.
//     -> matches a scoreboard reference model bit-exactly.

Source files
------------

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types, latency constant and round/saturate helper for the FFT datapath
package fft_pkg;

    localparam int MULT_LAT = 4;
    localparam int SAT_W    = 64;

    typedef struct packed {
        logic signed [SAT_W-1:0] re;
        logic signed [SAT_W-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic signed [SAT_W-1:0] value;
        logic                    ovf;
    } sat_res_t;

    // Round half up, arithmetic shift right, then clamp to a signed ow-bit range.
    function automatic sat_res_t sat_round(
        input logic signed [SAT_W-1:0] sum,
        input int                      shift,
        input int                      ow
    );
        logic signed [SAT_W-1:0] half;
        logic signed [SAT_W-1:0] rnd;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_res_t                res;
        half = 64'sd1 <<< (shift - 1);
        rnd  = (sum + half) >>> shift;
        hi   = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo   = -(64'sd1 <<< (ow - 1));
        res.ovf   = 1'b0;
        res.value = rnd;
        if (rnd > hi) begin
            res.value = hi;
            res.ovf   = 1'b1;
        end else if (rnd < lo) begin
            res.value = lo;
            res.ovf   = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fft_round_sat.sv
// rtl/fft_round_sat.sv - combinational round, shift and saturate of one product sum component
module fft_round_sat #(
    parameter int IW    = 44,
    parameter int SHIFT = 17,
    parameter int OW    = 25
) (
    input  logic signed [IW-1:0] i_sum,
    output logic signed [OW-1:0] o_val,
    output logic                 o_ovf
);
    import fft_pkg::*;

    logic signed [SAT_W-1:0] w_sum_ext;
    sat_res_t                w_res;
    logic                    w_unused_hi;

    assign w_sum_ext   = {{(SAT_W-IW){i_sum[IW-1]}}, i_sum};
    assign w_res       = sat_round(w_sum_ext, SHIFT, OW);
    assign o_val       = w_res.value[OW-1:0];
    assign o_ovf       = w_res.ovf;
    // After clamping the upper bits are pure sign extension.
    assign w_unused_hi = ^w_res.value[SAT_W-1:OW];

endmodule

// File: rtl/fft_cmplx_twiddle_mult.sv
// rtl/fft_cmplx_twiddle_mult.sv - 4-stage pipelined complex sample x twiddle multiplier with stall flow control
module fft_cmplx_twiddle_mult #(
    parameter int DW    = 25,
    parameter int TW    = 18,
    parameter int OW    = DW,
    parameter int TAG_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    input  logic [2*DW-1:0]     s_data_i,
    input  logic [2*TW-1:0]     w_i,
    input  logic                conj_i,
    input  logic [TAG_W-1:0]    tag_i,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic [2*OW-1:0]     m_data_o,
    output logic [TAG_W-1:0]    m_tag_o,
    output logic                m_ovf_o
);
    import fft_pkg::*;

    localparam int PW = DW + TW;
    localparam int SW = PW + 1;

    logic                   w_advance;

    logic                   r_v1, r_v2, r_v3, r_m_valid;

    logic signed [DW-1:0]   r_a, r_b;
    logic signed [TW-1:0]   r_c, r_d;
    logic                   r_conj1;
    logic [TAG_W-1:0]       r_tag1;

    logic signed [PW-1:0]   r_ac, r_bd, r_ad, r_bc;
    logic                   r_conj2;
    logic [TAG_W-1:0]       r_tag2;

    logic signed [SW-1:0]   r_re_sum, r_im_sum;
    logic [TAG_W-1:0]       r_tag3;

    logic [2*OW-1:0]        r_m_data;
    logic [TAG_W-1:0]       r_m_tag;
    logic                   r_m_ovf;

    logic signed [PW-1:0]   w_a_x, w_b_x, w_c_x, w_d_x;
    logic signed [SW-1:0]   w_ac_x, w_bd_x, w_ad_x, w_bc_x;
    logic signed [OW-1:0]   w_re_out, w_im_out;
    logic                   w_re_ovf, w_im_ovf;

    // A stall freezes every stage together; bubbles stay in place.
    assign w_advance = !r_m_valid || m_ready_i;
    assign s_ready_o = w_advance;

    assign w_a_x  = {{TW{r_a[DW-1]}}, r_a};
    assign w_b_x  = {{TW{r_b[DW-1]}}, r_b};
    assign w_c_x  = {{DW{r_c[TW-1]}}, r_c};
    assign w_d_x  = {{DW{r_d[TW-1]}}, r_d};

    assign w_ac_x = {r_ac[PW-1], r_ac};
    assign w_bd_x = {r_bd[PW-1], r_bd};
    assign w_ad_x = {r_ad[PW-1], r_ad};
    assign w_bc_x = {r_bc[PW-1], r_bc};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_v1      <= 1'b0;
            r_v2      <= 1'b0;
            r_v3      <= 1'b0;
            r_m_valid <= 1'b0;
        end else if (w_advance) begin
            r_v1      <= s_valid_i;
            r_v2      <= r_v1;
            r_v3      <= r_v2;
            r_m_valid <= r_v3;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a      <= '0;
            r_b      <= '0;
            r_c      <= '0;
            r_d      <= '0;
            r_conj1  <= 1'b0;
            r_tag1   <= '0;
            r_ac     <= '0;
            r_bd     <= '0;
            r_ad     <= '0;
            r_bc     <= '0;
            r_conj2  <= 1'b0;
            r_tag2   <= '0;
            r_re_sum <= '0;
            r_im_sum <= '0;
            r_tag3   <= '0;
        end else if (w_advance) begin
            r_a      <= s_data_i[2*DW-1:DW];
            r_b      <= s_data_i[DW-1:0];
            r_c      <= w_i[2*TW-1:TW];
            r_d      <= w_i[TW-1:0];
            r_conj1  <= conj_i;
            r_tag1   <= tag_i;

            r_ac     <= w_a_x * w_c_x;
            r_bd     <= w_b_x * w_d_x;
            r_ad     <= w_a_x * w_d_x;
            r_bc     <= w_b_x * w_c_x;
            r_conj2  <= r_conj1;
            r_tag2   <= r_tag1;

            // Conjugate twiddle flips the sign of d: (a+jb)(c-jd).
            r_re_sum <= r_conj2 ? (w_ac_x + w_bd_x) : (w_ac_x - w_bd_x);
            r_im_sum <= r_conj2 ? (w_bc_x - w_ad_x) : (w_ad_x + w_bc_x);
            r_tag3   <= r_tag2;
        end
    end

    fft_round_sat #(
        .IW    (SW),
        .SHIFT (TW - 1),
        .OW    (OW)
    ) u_rs_re (
        .i_sum (r_re_sum),
        .o_val (w_re_out),
        .o_ovf (w_re_ovf)
    );

    fft_round_sat #(
        .IW    (SW),
        .SHIFT (TW - 1),
        .OW    (OW)
    ) u_rs_im (
        .i_sum (r_im_sum),
        .o_val (w_im_out),
        .o_ovf (w_im_ovf)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_m_data <= '0;
            r_m_tag  <= '0;
            r_m_ovf  <= 1'b0;
        end else if (w_advance) begin
            r_m_data <= {w_re_out, w_im_out};
            r_m_tag  <= r_tag3;
            r_m_ovf  <= r_v3 && (w_re_ovf || w_im_ovf);
        end
    end

    assign m_valid_o = r_m_valid;
    assign m_data_o  = r_m_data;
    assign m_tag_o   = r_m_tag;
    assign m_ovf_o   = r_m_ovf;

endmodule
